// File: rtl/eq_tap_search.sv
// TX equalizer tap search: sweeps the FIR tap code, scores each code by eye opening, locks the best.
// Optional EQ_SEARCH_AVG_EN: score each code by the mean of two consecutive measurement windows.
module eq_tap_search #(
  parameter int TAP_BITS       = 4,
  parameter int TAP_MIN        = 0,
  parameter int TAP_MAX        = 15,
  parameter int SETTLE_WINDOWS = 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  real                 i_opening,
  input  logic                i_opening_ready,
  output logic [TAP_BITS-1:0] o_tap_code,
  output real                 o_best_opening,
  output logic                o_busy,
  output logic                o_done
);

  // state   | meaning
  // IDLE    | waiting for the first start after reset
  // SETTLE  | discarding windows after a tap code change
  // MEASURE | scoring the current tap code
  // DONE    | sweep complete, best code locked on the FIR
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [TAP_BITS-1:0] LP_TAP_MIN = TAP_BITS'(TAP_MIN);
  localparam logic [TAP_BITS-1:0] LP_TAP_MAX = TAP_BITS'(TAP_MAX);
  localparam logic [3:0]          LP_SETTLE  = 4'(SETTLE_WINDOWS);
  localparam state_t              LP_ENTRY   = (SETTLE_WINDOWS == 0) ? ST_MEASURE : ST_SETTLE;

  state_t              r_state;
  logic [TAP_BITS-1:0] r_tap_code;
  logic [TAP_BITS-1:0] r_best_code;
  logic                r_best_valid;
  real                 r_best_opening;
  logic                r_busy;
  logic                r_done;
  logic [3:0]          r_disc_cnt;
`ifdef EQ_SEARCH_AVG_EN
  logic                r_phase;
  real                 r_first;
`endif

  real                 w_score;
  logic                w_score_ready;
  logic                w_win;

  always_comb begin
`ifdef EQ_SEARCH_AVG_EN
    w_score       = (r_first + i_opening) / 2.0;
    w_score_ready = r_phase;
`else
    w_score       = i_opening;
    w_score_ready = 1'b1;
`endif
    // strict compare: on a tie the earlier (lower) code is kept
    w_win = !r_best_valid || (w_score > r_best_opening);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_tap_code     <= LP_TAP_MIN;
      r_best_code    <= LP_TAP_MIN;
      r_best_valid   <= 1'b0;
      r_best_opening <= 0.0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_disc_cnt     <= 4'd0;
`ifdef EQ_SEARCH_AVG_EN
      r_phase        <= 1'b0;
      r_first        <= 0.0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_tap_code     <= LP_TAP_MIN;
            r_best_valid   <= 1'b0;
            r_best_opening <= 0.0;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
            r_disc_cnt     <= LP_SETTLE;
`ifdef EQ_SEARCH_AVG_EN
            r_phase        <= 1'b0;
`endif
            r_state        <= LP_ENTRY;
          end
        end
        ST_SETTLE: begin
          if (i_opening_ready) begin
            r_disc_cnt <= r_disc_cnt - 4'd1;
            if (r_disc_cnt <= 4'd1) r_state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (i_opening_ready) begin
            if (!w_score_ready) begin
`ifdef EQ_SEARCH_AVG_EN
              r_first <= i_opening;
              r_phase <= 1'b1;
`endif
            end else begin
`ifdef EQ_SEARCH_AVG_EN
              r_phase <= 1'b0;
`endif
              if (w_win) begin
                r_best_opening <= w_score;
                r_best_code    <= r_tap_code;
                r_best_valid   <= 1'b1;
              end
              if (r_tap_code == LP_TAP_MAX) begin
                // the current code may have won on this very strobe
                r_tap_code <= w_win ? r_tap_code : r_best_code;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_state    <= ST_DONE;
              end else begin
                r_tap_code <= r_tap_code + TAP_BITS'(1);
                r_disc_cnt <= LP_SETTLE;
                r_state    <= LP_ENTRY;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_tap_code     = r_tap_code;
  assign o_best_opening = r_best_opening;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule
